// File: rtl/rtc_pkg.sv
// Shared RTC definitions: counter constants, alarm register map, bit positions
// and the alarm state encoding.
package rtc_pkg;

  localparam int unsigned RTC_CLK_HZ = 25_000_000;
  localparam int unsigned RTC_WIDTH  = 32;

  localparam int unsigned ALARM_NUM_REGS = 4;
  localparam logic [1:0]  ADDR_ALARM     = 2'd0;
  localparam logic [1:0]  ADDR_PERIOD    = 2'd1;
  localparam logic [1:0]  ADDR_CTRL      = 2'd2;
  localparam logic [1:0]  ADDR_STATUS    = 2'd3;

  localparam int unsigned CTRL_ENABLE_BIT    = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT    = 1;
  localparam int unsigned STATUS_PENDING_BIT = 0;
  localparam int unsigned STATUS_OVERRUN_BIT = 1;

  // The state encoding doubles as CTRL.enable.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } alarm_state_e;

endpackage

// File: rtl/rtc_alarm_if.sv
// Register bus for the RTC alarm block: one write strobe, combinational read.
interface rtc_alarm_if;
  import rtc_pkg::*;

  logic [1:0]           addr;
  logic                 wr_en;
  logic [RTC_WIDTH-1:0] data_in;
  logic [RTC_WIDTH-1:0] data_out;

  modport master (output addr, wr_en, data_in, input data_out);
  modport slave  (input addr, wr_en, data_in, output data_out);

endinterface

// File: rtl/rtc_alarm.sv
// RTC alarm: compares the seconds counter against ALARM, optionally reloading
// by PERIOD, and raises a maskable sticky interrupt.
module rtc_alarm
  import rtc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RTC_WIDTH-1:0] seconds_in,
  rtc_alarm_if.slave           bus,
  output logic                 irq
);

  alarm_state_e         state_q, state_d;
  logic [RTC_WIDTH-1:0] alarm_q, alarm_d;
  logic [RTC_WIDTH-1:0] period_q, period_d;
  logic                 irq_en_q, irq_en_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;

  logic                 match;
  logic [RTC_WIDTH-1:0] reload_sum;

  assign match      = (state_q == ST_ARMED) && (seconds_in == alarm_q);
  assign reload_sum = alarm_q + period_q;

  // NOTE: every signal gets its default before any branch so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    alarm_d   = alarm_q;
    period_d  = period_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    // Match side effects first, so a same-cycle bus write overrides them.
    if (match) begin
      if (period_q != '0) alarm_d = reload_sum;
      else                state_d = ST_IDLE;
    end

    if (bus.wr_en) begin
      unique case (bus.addr)
        ADDR_ALARM:  alarm_d  = bus.data_in;
        ADDR_PERIOD: period_d = bus.data_in;
        ADDR_CTRL: begin
          state_d  = alarm_state_e'(bus.data_in[CTRL_ENABLE_BIT]);
          irq_en_d = bus.data_in[CTRL_IRQ_EN_BIT];
        end
        ADDR_STATUS: begin
          if (bus.data_in[STATUS_PENDING_BIT]) pending_d = 1'b0;
          if (bus.data_in[STATUS_OVERRUN_BIT]) overrun_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Setting events come after the W1C so that set wins.
    if (match) begin
      pending_d = 1'b1;
      if (pending_q) overrun_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      alarm_q   <= '0;
      period_q  <= '0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alarm_q   <= alarm_d;
      period_q  <= period_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    bus.data_out = '0;
    unique case (bus.addr)
      ADDR_ALARM:  bus.data_out = alarm_q;
      ADDR_PERIOD: bus.data_out = period_q;
      ADDR_CTRL: begin
        bus.data_out[CTRL_ENABLE_BIT] = (state_q == ST_ARMED);
        bus.data_out[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      ADDR_STATUS: begin
        bus.data_out[STATUS_PENDING_BIT] = pending_q;
        bus.data_out[STATUS_OVERRUN_BIT] = overrun_q;
      end
      default: ;
    endcase
  end

  assign irq = pending_q & irq_en_q;

endmodule

// File: tb/tb_rtc_alarm.sv
// Directed self-checking bench for rtc_alarm: one-shot, periodic, wrap,
// overrun, RTC jump, same-cycle collisions and mid-operation reset.
module tb_rtc_alarm;
  import rtc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] seconds_in;
  logic        irq;
  int          n_checks = 0;
  int          n_fails  = 0;

  rtc_alarm_if bus ();

  rtc_alarm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seconds_in (seconds_in),
    .bus        (bus.slave),
    .irq        (irq)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.data_out, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr    = a;
    bus.data_in = d;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    seconds_in  = '0;
    bus.addr    = '0;
    bus.wr_en   = 1'b0;
    bus.data_in = '0;
    #5;

    // Reset state
    tick(); tick();
    check_reg("rst_alarm",  ADDR_ALARM,  32'h0);
    check_reg("rst_period", ADDR_PERIOD, 32'h0);
    check_reg("rst_ctrl",   ADDR_CTRL,   32'h0);
    check_reg("rst_status", ADDR_STATUS, 32'h0);
    check_irq("rst_irq", 1'b0);
    rst_n = 1'b1;

    // One-shot: ALARM=100, PERIOD=0, seconds 98..101
    seconds_in = 32'd98;
    wr(ADDR_ALARM, 32'd100);
    wr(ADDR_PERIOD, 32'd0);
    wr(ADDR_CTRL, 32'h3);
    seconds_in = 32'd99;  tick();
    check_reg("os_status_99", ADDR_STATUS, 32'h0);
    seconds_in = 32'd100;
    check_irq("os_irq_at_100", 1'b0);
    tick();
    check_reg("os_status_fire", ADDR_STATUS, 32'h1);
    check_irq("os_irq_fire", 1'b1);
    check_reg("os_ctrl", ADDR_CTRL, 32'h2);
    seconds_in = 32'd101; tick();
    check_reg("os_alarm_kept", ADDR_ALARM, 32'd100);
    wr(ADDR_STATUS, 32'h1);
    check_reg("os_w1c", ADDR_STATUS, 32'h0);
    check_irq("os_irq_clear", 1'b0);

    // Periodic: ALARM=10, PERIOD=5, seconds 0..30
    seconds_in = 32'd0;
    wr(ADDR_ALARM, 32'd10);
    wr(ADDR_PERIOD, 32'd5);
    wr(ADDR_CTRL, 32'h3);
    for (int s = 0; s <= 30; s++) begin
      seconds_in = s;
      tick();
      if (s >= 10 && s % 5 == 0) begin
        check_reg($sformatf("per_fire_%0d", s), ADDR_STATUS, 32'h1);
        check_irq($sformatf("per_irq_%0d", s), 1'b1);
        wr(ADDR_STATUS, 32'h1);
      end else begin
        check_reg($sformatf("per_quiet_%0d", s), ADDR_STATUS, 32'h0);
      end
    end
    check_reg("per_alarm_end", ADDR_ALARM, 32'd35);
    check_reg("per_ctrl_end", ADDR_CTRL, 32'h3);

    // Wrap-around
    wr(ADDR_ALARM, 32'hFFFF_FFFE);
    wr(ADDR_PERIOD, 32'd3);
    seconds_in = 32'hFFFF_FFFE; tick();
    check_reg("wrap_alarm", ADDR_ALARM, 32'h0000_0001);
    check_reg("wrap_ctrl", ADDR_CTRL, 32'h3);
    check_reg("wrap_status", ADDR_STATUS, 32'h1);

    // Overrun: pending still 1 from the wrap fire, ALARM=1
    seconds_in = 32'd1; tick();
    check_reg("ovr_status", ADDR_STATUS, 32'h3);
    wr(ADDR_STATUS, 32'h1);
    check_reg("ovr_w1c_pending", ADDR_STATUS, 32'h2);
    seconds_in = 32'd4; tick();
    check_reg("ovr_refire", ADDR_STATUS, 32'h3);
    seconds_in = 32'd7;
    wr(ADDR_STATUS, 32'h3);
    check_reg("ovr_w1c_vs_set", ADDR_STATUS, 32'h3);
    check_reg("ovr_alarm", ADDR_ALARM, 32'd10);
    wr(ADDR_STATUS, 32'h3);
    check_reg("ovr_cleared", ADDR_STATUS, 32'h0);

    // Same-cycle ALARM write and match: match uses old ALARM, write wins
    seconds_in = 32'd10;
    wr(ADDR_ALARM, 32'd99);
    check_reg("coll_alarm_write_wins", ADDR_ALARM, 32'd99);
    check_reg("coll_alarm_fired", ADDR_STATUS, 32'h1);
    wr(ADDR_STATUS, 32'h3);

    // Same-cycle CTRL write and one-shot match: written enable wins
    wr(ADDR_PERIOD, 32'd0);
    wr(ADDR_ALARM, 32'd300);
    seconds_in = 32'd300;
    wr(ADDR_CTRL, 32'h3);
    check_reg("coll_ctrl_wins", ADDR_CTRL, 32'h3);
    check_reg("coll_ctrl_fired", ADDR_STATUS, 32'h1);
    tick();
    check_reg("coll_ctrl_oneshot", ADDR_CTRL, 32'h2);
    check_reg("coll_ctrl_overrun", ADDR_STATUS, 32'h3);
    wr(ADDR_STATUS, 32'h3);

    // ALARM already equal when enable is set
    wr(ADDR_ALARM, 32'd5);
    seconds_in = 32'd5;
    wr(ADDR_CTRL, 32'h1);
    check_reg("pre_eq_not_yet", ADDR_STATUS, 32'h0);
    tick();
    check_reg("pre_eq_fire", ADDR_STATUS, 32'h1);
    check_irq("pre_eq_irq_masked", 1'b0);
    wr(ADDR_STATUS, 32'h1);

    // RTC jump past ALARM
    seconds_in = 32'd40;
    wr(ADDR_ALARM, 32'd50);
    wr(ADDR_CTRL, 32'h3);
    seconds_in = 32'd60; tick(); tick();
    check_reg("jump_status", ADDR_STATUS, 32'h0);
    check_irq("jump_irq", 1'b0);
    check_reg("jump_ctrl", ADDR_CTRL, 32'h3);
    wr(ADDR_ALARM, 32'd60);
    check_reg("jump_wr_not_yet", ADDR_STATUS, 32'h0);
    tick();
    check_reg("jump_wr_fire", ADDR_STATUS, 32'h1);
    check_irq("jump_wr_irq", 1'b1);
    wr(ADDR_STATUS, 32'h3);

    // Reset on the match cycle
    seconds_in = 32'd199;
    wr(ADDR_ALARM, 32'd200);
    wr(ADDR_PERIOD, 32'd7);
    wr(ADDR_CTRL, 32'h3);
    seconds_in = 32'd200;
    rst_n = 1'b0;
    tick();
    check_reg("mid_rst_alarm",  ADDR_ALARM,  32'h0);
    check_reg("mid_rst_period", ADDR_PERIOD, 32'h0);
    check_reg("mid_rst_ctrl",   ADDR_CTRL,   32'h0);
    check_reg("mid_rst_status", ADDR_STATUS, 32'h0);
    check_irq("mid_rst_irq", 1'b0);
    rst_n = 1'b1;
    seconds_in = 32'd0;
    tick();
    check_reg("post_rst_status_1", ADDR_STATUS, 32'h0);
    tick();
    check_reg("post_rst_status_2", ADDR_STATUS, 32'h0);
    check_irq("post_rst_irq", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rtc_alarm.md
RTC_ALARM -- requirements
Module: rtc_alarm

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock (25 MHz); every port is synchronous to it.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 seconds_in  input  32  current seconds value from the RTC counter in the same clock domain.
REQ-005 addr  input  2  register select: 0 ALARM, 1 PERIOD, 2 CTRL, 3 STATUS.
REQ-006 wr_en  input  1  single-cycle register write strobe.
REQ-007 data_in  input  32  write data.
REQ-008 data_out  output  32  read data for addr; combinational from registers; unused bits read 0.
REQ-009 irq  output  1  alarm interrupt, equal to STATUS.pending AND CTRL.irq_en.

Function
REQ-010 ALARM SHALL be a 32-bit read/write compare value.
REQ-011 PERIOD SHALL be a 32-bit read/write reload interval; 0 selects one-shot mode.
REQ-012 CTRL SHALL hold bit0 enable and bit1 irq_en; both bits are read/write.
REQ-013 STATUS SHALL hold bit0 pending and bit1 overrun; both are write-1-to-clear, and writing 0 has no effect.
REQ-014 The state machine SHALL have two states: IDLE (enable=0) and ARMED (enable=1); the state is CTRL.enable itself.
REQ-015 Match SHALL be defined as ARMED AND seconds_in == ALARM, evaluated every cycle using equality only; an RTC jump past ALARM does not fire.
REQ-016 On match, pending SHALL be set on the next clock edge, so irq rises 1 cycle after seconds_in equals ALARM.
REQ-017 On match with pending already 1, overrun SHALL be set on the same edge.
REQ-018 On match with PERIOD != 0, ALARM SHALL be updated to ALARM + PERIOD mod 2^32 on the same edge, and the block stays ARMED; this prevents a double fire within one second.
REQ-019 On match with PERIOD == 0, enable SHALL be cleared on the same edge (IDLE); ALARM is unchanged.
REQ-020 On a same-cycle ALARM bus write and match, the match SHALL use the old ALARM value, and the written value SHALL win over the reload.
REQ-021 On a same-cycle CTRL write and one-shot match, the written enable value SHALL win.
REQ-022 On a same-cycle W1C of pending or overrun and a setting event, set SHALL win.
REQ-023 If ALARM already equals seconds_in when enable is set, the block SHALL fire on the next cycle.
REQ-024 Clearing enable SHALL NOT clear pending or overrun.

Reset
REQ-025 While rst_n=0 at a clock edge, ALARM, PERIOD, CTRL and STATUS SHALL become 0; the state is IDLE, irq=0 and data_out reads 0 for all addresses.
REQ-026 Reset asserted mid-operation SHALL abandon any in-progress match or reload, and no event SHALL be generated on the first cycle after release.

Structure
REQ-027 The register offsets, CTRL and STATUS bit positions, and register count SHALL be defined in the shared package rtc_pkg, alongside the RTC counter constants.
REQ-028 The block SHALL be a single module with no sub-module.
REQ-029 The implementation SHALL use one 32-bit adder for the reload and one 32-bit equality comparator.

Verification
REQ-030 The bench SHALL cover the one-shot case: ALARM=100, PERIOD=0, enable=1, irq_en=1, seconds_in steps 98→101. Required: pending=1 and irq=1 exactly 1 cycle after seconds_in==100, then CTRL reads 0x2.
REQ-031 The bench SHALL cover the periodic case: ALARM=10, PERIOD=5, seconds_in counts 0→30. Required: fires at 10, 15, 20, 25 and 30, with pending cleared by W1C between fires; ALARM reads 35 at the end.
REQ-032 The bench SHALL cover wrap-around: ALARM=0xFFFFFFFE, PERIOD=3, match. Required: ALARM reads 0x00000001 and the block stays ARMED.
REQ-033 The bench SHALL cover overrun: a periodic match occurs while pending=1. Required: STATUS reads 0x3; writing 0x1 leaves 0x2; a W1C of pending in the same cycle as a match leaves pending=1.
REQ-034 The bench SHALL cover an RTC jump: ALARM=50, seconds_in jumps 40→60. Required: no fire and STATUS=0. Then writing ALARM=60 while seconds_in=60 and ARMED fires on the next cycle.
REQ-035 The bench SHALL cover reset mid-operation: rst_n=0 on the match cycle. Required: all registers read 0, irq=0, and no pending after rst_n=1.
